// File: rtl/rm_lane_scheduler.sv
// Lane retirement scheduler: round-robin over finished/timed-out lanes, plus a flush sweep of all busy lanes.
// Selection costs one registered IDLE cycle; the command holds in ISSUE until rst_ready_i, and a flush preempts it.
module rm_lane_scheduler #(
  parameter int  NUM_LANES = 4,
  parameter int  TIMEOUT   = 255,
  localparam int LW        = $clog2(NUM_LANES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [NUM_LANES-1:0] lane_busy_i,
  input  logic [NUM_LANES-1:0] done_req_i,
  input  logic [NUM_LANES-1:0] done_err_i,
  output logic [NUM_LANES-1:0] done_gnt_o,
  output logic                 rst_valid_o,
  output logic [LW-1:0]        rst_lane_o,
  output logic                 rst_timeout_o,
  input  logic                 rst_ready_i,
  output logic                 err_o,
  output logic [LW-1:0]        err_lane_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t                    state;
  logic [LW-1:0]             rr_ptr;
  logic [LW-1:0]             rr_lane;
  logic [LW-1:0]             rr_idx;
  logic [LW-1:0]             flush_lane;
  logic [LW-1:0]             err_lane_q;
  logic [NUM_LANES-1:0]      flush_mask;
  logic [NUM_LANES-1:0]      mask_nxt;
  logic [NUM_LANES-1:0]      eligible;
  logic [NUM_LANES-1:0]      lane_hs;
  logic [NUM_LANES-1:0][7:0] cnt;
  logic                      rr_found;
  logic                      hs;
  logic                      issue_hs;
  logic                      flush_enter;

  assign hs          = rst_valid_o && rst_ready_i;
  assign issue_hs    = hs && (state == ISSUE);
  assign flush_enter = flush_i && (state != FLUSH);

  // Grant and error are combinational so a requester can drop done_req_i right after the accepting edge.
  assign err_o      = issue_hs && done_req_i[rst_lane_o] && done_err_i[rst_lane_o];
  assign err_lane_o = err_o ? rst_lane_o : err_lane_q;

  always_comb begin
    eligible   = '0;
    lane_hs    = '0;
    done_gnt_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      eligible[i]   = lane_busy_i[i] && (done_req_i[i] || (cnt[i] == TO));
      lane_hs[i]    = hs && (rst_lane_o == LW'(i));
      done_gnt_o[i] = issue_hs && (rst_lane_o == LW'(i)) && done_req_i[i];
    end
  end

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_lane  = '0;
    rr_idx   = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      rr_idx = LW'((int'(rr_ptr) + k) % NUM_LANES);
      if (eligible[rr_idx]) begin
        rr_found = 1'b1;
        rr_lane  = rr_idx;
      end
    end
  end

  always_comb begin
    mask_nxt = '0;
    if (state == FLUSH) begin
      mask_nxt = (flush_mask & ~lane_hs) | (flush_i ? lane_busy_i : '0);
    end else if (flush_i) begin
      mask_nxt = lane_busy_i;
    end
    flush_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_nxt[i]) flush_lane = LW'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      flush_mask    <= '0;
      err_lane_q    <= '0;
      cnt           <= '0;
      rst_valid_o   <= 1'b0;
      rst_lane_o    <= '0;
      rst_timeout_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!lane_busy_i[i] || lane_hs[i] || flush_enter) begin
          cnt[i] <= '0;
        end else if (!done_req_i[i] && (cnt[i] != TO)) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end

      if (issue_hs) begin
        rr_ptr <= (rst_lane_o == LW'(NUM_LANES - 1)) ? '0 : rst_lane_o + 1'b1;
      end
      if (err_o) err_lane_q <= rst_lane_o;

      // The flush sweep precomputes its next lane so the command output stays registered.
      if ((state == FLUSH) || flush_i) begin
        flush_mask    <= mask_nxt;
        rst_valid_o   <= |mask_nxt;
        rst_lane_o    <= flush_lane;
        rst_timeout_o <= 1'b0;
        state         <= ((state == FLUSH) && (mask_nxt == '0) && !flush_i) ? IDLE : FLUSH;
      end else begin
        case (state)
          IDLE: begin
            if (rr_found) begin
              state         <= ISSUE;
              rst_valid_o   <= 1'b1;
              rst_lane_o    <= rr_lane;
              rst_timeout_o <= !done_req_i[rr_lane];
            end
          end
          ISSUE: begin
            if (hs || !lane_busy_i[rst_lane_o]) begin
              state       <= IDLE;
              rst_valid_o <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            rst_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rm_lane_scheduler.sv
// Directed bench for rm_lane_scheduler (NUM_LANES=4, TIMEOUT=4): per-cycle vector table plus timeout and reset sequences.
module tb_rm_lane_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       rdy;
  logic [3:0] busy;
  logic [3:0] req;
  logic [3:0] errin;
  logic [3:0] gnt;
  logic       valid;
  logic       tmo;
  logic       erro;
  logic [1:0] lane;
  logic [1:0] elane;
  logic [10:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rm_lane_scheduler #(.NUM_LANES(4), .TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .lane_busy_i  (busy),
    .done_req_i   (req),
    .done_err_i   (errin),
    .done_gnt_o   (gnt),
    .rst_valid_o  (valid),
    .rst_lane_o   (lane),
    .rst_timeout_o(tmo),
    .rst_ready_i  (rdy),
    .err_o        (erro),
    .err_lane_o   (elane)
  );

  assign obs = {valid, lane, tmo, gnt, erro, elane};

  typedef struct {
    logic        flush;
    logic [3:0]  busy;
    logic [3:0]  req;
    logic [3:0]  err;
    logic        rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs for one cycle, then the outputs expected during that same cycle.
  task automatic add(input logic f, input logic [3:0] b, input logic [3:0] r, input logic [3:0] e,
                     input logic y, input logic v, input logic [1:0] l, input logic t,
                     input logic [3:0] g, input logic eo, input logic [1:0] el);
    vec_t x;
    x.flush = f;
    x.busy  = b;
    x.req   = r;
    x.err   = e;
    x.rdy   = y;
    x.exp   = {v, l, t, g, eo, el};
    tbl.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    rdy   = 1'b0;
    busy  = '0;
    req   = '0;
    errin = '0;

    // Round robin from lane 0: lanes 1 then 3, rr_ptr wraps to 0
    add(0, 4'b1111, 4'b1010, 4'b0000, 1,  0, 2'd0, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1111, 4'b1010, 4'b0000, 1,  1, 2'd1, 0, 4'b0010, 0, 2'd0);
    add(0, 4'b1111, 4'b1000, 4'b0000, 1,  0, 2'd1, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1111, 4'b1000, 4'b0000, 1,  1, 2'd3, 0, 4'b1000, 0, 2'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1,  0, 2'd3, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1001, 4'b1001, 4'b0000, 0,  0, 2'd3, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1001, 4'b1001, 4'b0000, 1,  1, 2'd0, 0, 4'b0001, 0, 2'd0);
    add(0, 4'b1001, 4'b1000, 4'b0000, 1,  0, 2'd0, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b1001, 4'b1000, 4'b0000, 1,  1, 2'd3, 0, 4'b1000, 0, 2'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd3, 0, 4'b0000, 0, 2'd0);
    // Lane 2 stalled five cycles, then accepted with a violation
    add(0, 4'b0100, 4'b0100, 4'b0100, 0,  0, 2'd3, 0, 4'b0000, 0, 2'd0);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0100, 4'b0100, 4'b0100, 0,  1, 2'd2, 0, 4'b0000, 0, 2'd0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1,  1, 2'd2, 0, 4'b0100, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd2, 0, 4'b0000, 0, 2'd2);
    // Flush drops pending lane 3, sweeps 0, 2, 3 with no grant or error
    add(0, 4'b1101, 4'b1000, 4'b0000, 0,  0, 2'd2, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b1101, 4'b1000, 4'b0000, 0,  1, 2'd3, 0, 4'b0000, 0, 2'd2);
    add(1, 4'b1101, 4'b1000, 4'b0000, 0,  1, 2'd3, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b1101, 4'b1000, 4'b1101, 1,  1, 2'd0, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b1101, 4'b1000, 4'b1101, 1,  1, 2'd2, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b1101, 4'b1000, 4'b1101, 1,  1, 2'd3, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd0, 0, 4'b0000, 0, 2'd2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd0, 0, 4'b0000, 0, 2'd2);
    // Flush together with a handshake: handshake completes, then flush sweep
    add(0, 4'b0010, 4'b0010, 4'b0010, 0,  0, 2'd0, 0, 4'b0000, 0, 2'd2);
    add(1, 4'b0010, 4'b0010, 4'b0010, 1,  1, 2'd1, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 4'b0000, 4'b0000, 1,  1, 2'd1, 0, 4'b0000, 0, 2'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd0, 0, 4'b0000, 0, 2'd1);
    // rr_ptr=2 picks lane 3; busy drop withdraws the command
    add(0, 4'b1011, 4'b1011, 4'b0000, 0,  0, 2'd0, 0, 4'b0000, 0, 2'd1);
    add(0, 4'b1011, 4'b1011, 4'b0000, 0,  1, 2'd3, 0, 4'b0000, 0, 2'd1);
    add(0, 4'b0011, 4'b1011, 4'b0000, 0,  1, 2'd3, 0, 4'b0000, 0, 2'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd3, 0, 4'b0000, 0, 2'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0,  0, 2'd3, 0, 4'b0000, 0, 2'd1);

    #3;
    check("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      flush = tbl[i].flush;
      busy  = tbl[i].busy;
      req   = tbl[i].req;
      errin = tbl[i].err;
      rdy   = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // Timeout: lane 0 busy without a request, counter saturates at 4
    @(negedge clk);
    flush = 1'b0; busy = 4'b0001; req = '0; errin = '0; rdy = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (valid) break;
    end
    check("timeout_latency", 32'(n), 32'd5);
    check("timeout_cmd", 32'({valid, lane, tmo, gnt, erro}), 32'({1'b1, 2'd0, 1'b1, 4'b0000, 1'b0}));
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("timeout_no_gnt", 32'({valid, gnt, erro}), 32'({1'b1, 4'b0000, 1'b0}));
    @(posedge clk);
    #1;
    check("timeout_retired", 32'(valid), 32'd0);
    @(negedge clk);
    busy = '0; rdy = 1'b0;

    // Reset in the middle of a flush sweep
    @(negedge clk);
    busy = 4'b0110; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_cmd", 32'({valid, lane, tmo}), 32'({1'b1, 2'd1, 1'b0}));
    @(negedge clk);
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_flush", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy  = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_quiet%0d", i), 32'(valid), 32'd0);
    end
    @(negedge clk);
    busy = 4'b0100; req = 4'b0100;
    @(posedge clk);
    #1;
    check("post_reset_cmd", 32'({valid, lane, tmo}), 32'({1'b1, 2'd2, 1'b0}));
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("post_reset_gnt", 32'(gnt), 32'(4'b0100));
    @(negedge clk);
    busy = '0; req = '0; rdy = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_lane_scheduler.md
RM_LANE_SCHEDULER -- requirements
Module: rm_lane_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of runtime-monitor lanes scheduled.
REQ-002 Parameter TIMEOUT, default 255: idle-busy cycles before a lane is force-retired (1..255).
REQ-003 Localparam LW = $clog2(NUM_LANES): lane index width.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-006 flush_i  input  1  pipeline flush; retire all busy lanes.
REQ-007 lane_busy_i  input  NUM_LANES  lane holds an allocated instruction.
REQ-008 done_req_i  input  NUM_LANES  lane monitor finished, requests retirement.
REQ-009 done_err_i  input  NUM_LANES  finished lane detected a violation; qualified by done_req_i.
REQ-010 done_gnt_o  output  NUM_LANES  one-hot, one-cycle pulse: request accepted.
REQ-011 rst_valid_o  output  1  lane-reset command valid.
REQ-012 rst_lane_o  output  LW  lane to reset.
REQ-013 rst_timeout_o  output  1  command caused by timeout, not by done_req_i.
REQ-014 rst_ready_i  input  1  allocator accepts the command this cycle.
REQ-015 err_o  output  1  one-cycle pulse: accepted command carried a violation.
REQ-016 err_lane_o  output  LW  lane of the last err_o; holds until the next err_o.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and FLUSH.
REQ-018 Eligible set: done_req_i OR (timeout counter == TIMEOUT), masked by lane_busy_i.
REQ-019 IDLE: eligible set non-empty -> select a lane round-robin, starting at rr_ptr, and go to ISSUE next cycle; the selection is registered.
REQ-020 ISSUE: rst_valid_o=1, with rst_lane_o and rst_timeout_o held stable until rst_ready_i.
REQ-021 Handshake (rst_valid_o && rst_ready_i) in ISSUE: done_gnt_o[lane] pulses when done_req_i[lane]=1 that cycle; err_o pulses when done_err_i[lane]=1; rr_ptr <= lane+1 mod NUM_LANES; next state IDLE.
REQ-022 Handshake-to-next-command latency: a new command SHALL take at least one IDLE cycle.
REQ-023 rst_timeout_o=1 only if the selected lane had done_req_i=0 at selection.
REQ-024 If the selected lane's lane_busy_i drops in ISSUE before the handshake, the command SHALL be withdrawn (rst_valid_o=0 next cycle) with no gnt/err, and the next state SHALL be IDLE.
REQ-025 Per-lane 8-bit timeout counter: increments while lane_busy_i=1 and done_req_i=0; saturates at TIMEOUT.
REQ-026 Timeout counter clears to 0 on: lane_busy_i=0, that lane's handshake, or entry into FLUSH.
REQ-027 flush_i=1 in any state -> FLUSH next cycle; a pending ISSUE command is dropped, with no gnt/err.
REQ-028 On FLUSH entry, flush_mask <= lane_busy_i; flush_i while in FLUSH ORs lane_busy_i into flush_mask.
REQ-029 FLUSH: rst_valid_o=1 for the lowest set bit of flush_mask, with rst_timeout_o=0.
REQ-030 In FLUSH, each handshake clears that bit; done_gnt_o and err_o SHALL stay 0.
REQ-031 FLUSH exit: flush_mask==0 and flush_i=0 -> IDLE; rr_ptr unchanged.
REQ-032 Simultaneous flush_i and ISSUE handshake: the handshake completes (gnt/err pulse, rr_ptr advances) and the next state SHALL be FLUSH.
REQ-033 At most one rst_valid_o command per cycle; done_gnt_o SHALL always be zero or one-hot.

Reset
REQ-034 On rst_ni=0, asynchronously: state=IDLE, rr_ptr=0, flush_mask=0, all counters=0.
REQ-035 On rst_ni=0, asynchronously: rst_valid_o=0, rst_lane_o=0, rst_timeout_o=0, done_gnt_o=0, err_o=0, err_lane_o=0.
REQ-036 Reset asserted mid-ISSUE or mid-FLUSH SHALL abandon the command with no handshake side effects.

Verification
REQ-037 Busy=4'b1111, done_req=4'b1010, rst_ready_i=1 -> commands lane 1 then lane 3, with done_gnt_o 4'b0010 then 4'b1000 and rr_ptr=0 afterwards.
REQ-038 Busy=4'b0001, no done_req, TIMEOUT=4 -> rst_valid_o with lane 0 and rst_timeout_o=1 after the counter saturates; done_gnt_o stays 0.
REQ-039 ISSUE on lane 2 with rst_ready_i=0 for 5 cycles -> rst_lane_o stable at 2; on ready with done_err_i[2]=1 -> err_o pulse and err_lane_o=2.
REQ-040 Busy=4'b1101, flush_i pulse during ISSUE on lane 3 -> command dropped; FLUSH issues lanes 0, 2, 3 in order with no gnt; then IDLE.
REQ-041 Reset asserted during FLUSH with ready=0 -> all outputs 0 immediately; after release, no command until a lane becomes eligible.
